pb_intc: RTL and testbench

- Parametrised interrupt controller for the KCPSM-style processor port bus: port_id/out_port/in_port with write_strobe/read_strobe and an interrupt/interrupt_ack pair.
- Collects NUM_SRC asynchronous interrupt sources and applies per-source masking and edge/level mode.
- Drives the single processor interrupt line and holds it until the processor acknowledges.
- Exposes pending, mask, mode and a priority vector as port-mapped registers, so the top-level in_port read mux can be replaced by a real peripheral.

---
 rtl/pb_intc_pkg.sv | 25 ++
 rtl/pb_intc_sync.sv | 28 ++
 rtl/pb_intc.sv | 111 +++++++++++
 tb/tb_pb_intc.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_intc_pkg.sv
// rtl/pb_intc_pkg.sv - shared constants, FSM encoding and priority helper for pb_intc
package pb_intc_pkg;

   localparam logic [1:0] REG_PENDING = 2'd0;
   localparam logic [1:0] REG_MASK    = 2'd1;
   localparam logic [1:0] REG_MODE    = 2'd2;
   localparam logic [1:0] REG_VECTOR  = 2'd3;

   localparam int VECTOR_VALID_BIT = 7;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   // Index 0 has the highest priority, so scan downward and keep the last hit.
   function automatic logic [2:0] lowest_idx(input logic [7:0] v);
      lowest_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) lowest_idx = i[2:0];
      end
   endfunction

endpackage

// File: rtl/pb_intc_sync.sv
// rtl/pb_intc_sync.sv - per-source synchroniser chain with edge history
module pb_intc_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic irq,
   output logic level,
   output logic rise
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], irq};
         prev  <= chain[SYNC_STAGES-1];
      end
   end

   assign level = chain[SYNC_STAGES-1];
   assign rise  = level & ~prev;

endmodule

// File: rtl/pb_intc.sv
// rtl/pb_intc.sv - port-mapped interrupt controller for a KCPSM-style processor bus
module pb_intc
   import pb_intc_pkg::*;
#(
   parameter int         NUM_SRC     = 8,
   parameter logic [7:0] BASE_ADDR   = 8'h10,
   parameter int         SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         port_id,
   input  logic [7:0]         out_port,
   input  logic               write_strobe,
   input  logic               read_strobe,
   output logic [7:0]         rd_data,
   output logic               rd_hit,
   input  logic [NUM_SRC-1:0] irq_src,
   output logic               interrupt,
   input  logic               interrupt_ack
);

   logic [NUM_SRC-1:0] level, rise, pending, mask, mode, w1c;
   logic [7:0]         offset, pend8, mask8, mode8, active8, vector8;
   logic [2:0]         vec_idx, active_idx;
   logic               vec_valid, wr_en, int_q;
   logic               unused_ok;
   state_t             state, state_n;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
      pb_intc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .irq   (irq_src[g]),
         .level (level[g]),
         .rise  (rise[g])
      );
   end

   assign unused_ok = &{1'b0, read_strobe};

   assign offset = port_id - BASE_ADDR;
   assign rd_hit = (offset < 8'd4);
   assign wr_en  = write_strobe & rd_hit;
   assign w1c    = (wr_en && offset[1:0] == REG_PENDING) ? out_port[NUM_SRC-1:0] : '0;

   // Widen to the 8-bit bus so unimplemented source bits read as zero.
   always_comb begin
      pend8 = '0;
      mask8 = '0;
      mode8 = '0;
      pend8[NUM_SRC-1:0] = pending;
      mask8[NUM_SRC-1:0] = mask;
      mode8[NUM_SRC-1:0] = mode;
      active8   = pend8 & mask8;
      vec_valid = |active8;
      vec_idx   = lowest_idx(active8);
      vector8   = '0;
      vector8[VECTOR_VALID_BIT] = vec_valid;
      vector8[2:0]              = vec_idx;
   end

   always_comb begin
      rd_data = '0;
      if (rd_hit) begin
         case (offset[1:0])
            REG_PENDING: rd_data = pend8;
            REG_MASK:    rd_data = mask8;
            REG_MODE:    rd_data = mode8;
            default:     rd_data = vector8;
         endcase
      end
   end

   // Edge bits latch rises (a rise beats a same-cycle clear); level bits track the input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         mask    <= '0;
         mode    <= '0;
      end else begin
         pending <= (mode & (rise | (pending & ~w1c))) | (~mode & level);
         if (wr_en && offset[1:0] == REG_MASK) mask <= out_port[NUM_SRC-1:0];
         if (wr_en && offset[1:0] == REG_MODE) mode <= out_port[NUM_SRC-1:0];
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:    if (vec_valid) state_n = ST_ASSERT;
         ST_ASSERT:  if (interrupt_ack) state_n = vec_valid ? ST_SERVICE : ST_IDLE;
         ST_SERVICE: if (!pend8[active_idx] || !mask8[active_idx]) state_n = ST_IDLE;
         default:    state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         int_q      <= 1'b0;
         active_idx <= '0;
      end else begin
         state <= state_n;
         int_q <= (state_n == ST_ASSERT);
         if (state == ST_ASSERT && interrupt_ack && vec_valid) active_idx <= vec_idx;
      end
   end

   assign interrupt = int_q;

endmodule

// File: tb/tb_pb_intc.sv
// tb/tb_pb_intc.sv - scoreboard bench for pb_intc register map, latency and FSM
module tb_pb_intc;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] port_id = '0;
   logic [7:0] out_port = '0;
   logic       write_strobe = 1'b0;
   logic       read_strobe = 1'b0;
   logic [7:0] rd_data;
   logic       rd_hit;
   logic [7:0] irq_src = '0;
   logic       interrupt;
   logic       interrupt_ack = 1'b0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       do_rd;
      logic [7:0] exp_rd;
      logic       exp_hit;
      logic       do_int;
      logic       exp_int;
      string      name;
   } item_t;

   item_t sb[$];
   logic  obs_v = 1'b0;

   pb_intc #(.NUM_SRC(8), .BASE_ADDR(8'h10), .SYNC_STAGES(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .port_id       (port_id),
      .out_port      (out_port),
      .write_strobe  (write_strobe),
      .read_strobe   (read_strobe),
      .rd_data       (rd_data),
      .rd_hit        (rd_hit),
      .irq_src       (irq_src),
      .interrupt     (interrupt),
      .interrupt_ack (interrupt_ack)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   // Monitor: one scoreboard entry is consumed per observation window.
   always @(negedge clk) begin
      if (obs_v) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: observation with no expected entry");
         end else begin
            item_t it;
            it = sb.pop_front();
            if (it.do_rd) begin
               checks++;
               if (rd_data !== it.exp_rd) begin
                  errors++;
                  $display("FAIL %s rd_data: got %02h, expected %02h", it.name, rd_data, it.exp_rd);
               end
               checks++;
               if (rd_hit !== it.exp_hit) begin
                  errors++;
                  $display("FAIL %s rd_hit: got %b, expected %b", it.name, rd_hit, it.exp_hit);
               end
            end
            if (it.do_int) begin
               checks++;
               if (interrupt !== it.exp_int) begin
                  errors++;
                  $display("FAIL %s interrupt: got %b, expected %b", it.name, interrupt, it.exp_int);
               end
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data);
      port_id      = addr;
      out_port     = data;
      write_strobe = 1'b1;
      @(posedge clk);
      #1;
      write_strobe = 1'b0;
   endtask

   // Observes within the current cycle without crossing a rising edge.
   task automatic obs(input logic do_rd, input logic [7:0] addr, input logic [7:0] exp_rd,
                      input logic exp_hit, input logic do_int, input logic exp_int, input string name);
      item_t it;
      it.do_rd   = do_rd;
      it.exp_rd  = exp_rd;
      it.exp_hit = exp_hit;
      it.do_int  = do_int;
      it.exp_int = exp_int;
      it.name    = name;
      sb.push_back(it);
      if (do_rd) begin
         port_id     = addr;
         read_strobe = 1'b1;
      end
      obs_v = 1'b1;
      @(negedge clk);
      #1;
      obs_v       = 1'b0;
      read_strobe = 1'b0;
   endtask

   task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string name);
      obs(1'b1, addr, exp, 1'b1, 1'b0, 1'b0, name);
   endtask

   task automatic rdi(input logic [7:0] addr, input logic [7:0] exp, input logic exp_int, input string name);
      obs(1'b1, addr, exp, 1'b1, 1'b1, exp_int, name);
   endtask

   task automatic ck_int(input logic exp_int, input string name);
      obs(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, exp_int, name);
   endtask

   task automatic ack();
      interrupt_ack = 1'b1;
      tick();
      interrupt_ack = 1'b0;
   endtask

   initial begin
      tick(3);
      rst_n = 1'b1;
      tick();

      rdi(8'h10, 8'h00, 1'b0, "reset_pending");
      rd(8'h11, 8'h00, "reset_mask");
      rd(8'h12, 8'h00, "reset_mode");
      rd(8'h13, 8'h00, "reset_vector");
      obs(1'b1, 8'h14, 8'h00, 1'b0, 1'b0, 1'b0, "unmapped_14");

      // Single edge source, latency and W1C.
      wr(8'h11, 8'h04);
      wr(8'h12, 8'h04);
      irq_src[2] = 1'b1;
      tick();
      irq_src[2] = 1'b0;
      tick();
      rdi(8'h10, 8'h00, 1'b0, "lat_edge2");
      tick();
      rdi(8'h10, 8'h04, 1'b0, "lat_edge3");
      tick();
      rdi(8'h13, 8'h82, 1'b1, "lat_edge4_vector");
      ack();
      rdi(8'h10, 8'h04, 1'b0, "ack_drops_int");
      wr(8'h10, 8'h04);
      tick(2);
      rdi(8'h10, 8'h00, 1'b0, "w1c_clears");
      tick(3);
      rdi(8'h13, 8'h00, 1'b0, "no_reassert");

      // Two simultaneous edges: priority and re-arm with a low gap.
      wr(8'h11, 8'hFF);
      wr(8'h12, 8'hFF);
      irq_src = 8'h22;
      tick();
      irq_src = 8'h00;
      tick(3);
      rdi(8'h13, 8'h81, 1'b1, "prio_vector_81");
      rd(8'h10, 8'h22, "prio_pending_22");
      ack();
      wr(8'h10, 8'h02);
      rdi(8'h10, 8'h20, 1'b0, "prio_w1c_bit1");
      tick();
      ck_int(1'b0, "prio_low_gap");
      tick();
      rdi(8'h13, 8'h85, 1'b1, "prio_rearm_85");
      ack();
      wr(8'h10, 8'h20);
      tick(2);
      rdi(8'h10, 8'h00, 1'b0, "prio_cleanup");

      // Level source held high.
      wr(8'h12, 8'h00);
      wr(8'h11, 8'h01);
      irq_src[0] = 1'b1;
      tick(4);
      ck_int(1'b1, "level_assert");
      for (int i = 0; i < 20; i++) begin
         tick();
         ck_int(1'b1, "level_hold");
      end
      ack();
      ck_int(1'b0, "level_ack");
      wr(8'h10, 8'h01);
      rdi(8'h10, 8'h01, 1'b0, "level_w1c_ignored");
      irq_src[0] = 1'b0;
      tick(2);
      rd(8'h10, 8'h01, "level_fall_edge2");
      tick();
      rd(8'h10, 8'h00, "level_fall_edge3");
      tick(3);
      rdi(8'h13, 8'h00, 1'b0, "level_idle");

      // Set wins over simultaneous W1C; edge->level switch.
      wr(8'h11, 8'h00);
      wr(8'h12, 8'h08);
      irq_src[3] = 1'b1;
      tick(2);
      wr(8'h10, 8'h08);
      rd(8'h10, 8'h08, "set_wins_w1c");
      wr(8'h10, 8'h08);
      rd(8'h10, 8'h00, "edge_w1c");
      irq_src[3] = 1'b0;
      tick(4);
      irq_src[3] = 1'b1;
      tick(3);
      irq_src[3] = 1'b0;
      tick(4);
      rd(8'h10, 8'h08, "edge_holds");
      wr(8'h12, 8'h00);
      rd(8'h10, 8'h08, "switch_same_edge");
      tick();
      rd(8'h10, 8'h00, "switch_to_level");

      // Asynchronous reset while asserting.
      wr(8'h12, 8'h01);
      wr(8'h11, 8'h01);
      irq_src[0] = 1'b1;
      tick();
      irq_src[0] = 1'b0;
      tick(3);
      ck_int(1'b1, "rst_pre_assert");
      tick();
      rst_n = 1'b0;
      rdi(8'h11, 8'h00, 1'b0, "async_reset");
      tick();
      rst_n = 1'b1;
      tick(8);
      rdi(8'h10, 8'h00, 1'b0, "post_reset_quiet");
      rd(8'h12, 8'h00, "post_reset_mode");

      tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
